// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: exception entry / ERET sequencer for the CP0 register block.
// Accepts a pipeline exception, a masked hardware interrupt or an ERET while idle. It then
// drives the Cause/EPC/BadVAddr/Status hardware write ports over fixed cycles, and finishes
// with a one-cycle fetch redirect and an ack pulse.
// Optional build macro: CP0_EXC_IRQ_SYNC_EN adds a 2-flop synchronizer on irq.
module cp0_exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
   parameter int unsigned NIRQ       = 6
) (
   input  logic            clk,
   input  logic            res,
   input  logic            exc_req,
   input  logic [4:0]      exc_code,
   input  logic [31:0]     exc_pc,
   input  logic            exc_bd,
   input  logic            exc_badva_valid,
   input  logic [31:0]     exc_badva,
   input  logic [31:0]     int_pc,
   input  logic            int_bd,
   input  logic            eret_req,
   input  logic [NIRQ-1:0] irq,
   input  logic [31:0]     cp0_status,
   input  logic [31:0]     cp0_cause,
   input  logic [31:0]     cp0_epc,
   output logic [31:0]     in_epc,
   output logic [31:0]     in_status,
   output logic [31:0]     in_cause,
   output logic [31:0]     in_badVAddr,
   output logic            we_epc,
   output logic            we_status,
   output logic            we_cause,
   output logic            we_badVAddr,
   output logic            busy,
   output logic            flush,
   output logic            exc_ack,
   output logic            eret_ack,
   output logic            redirect_valid,
   output logic [31:0]     redirect_pc
);

   typedef enum logic [2:0] {StIdle, StSave, StSetExl, StEret, StRedir} state_e;

   state_e           state_q, state_d;
   logic             kind_eret_q;
   logic [4:0]       code_q;
   logic [31:0]      pc_q;
   logic             bd_q;
   logic             bv_q;
   logic [31:0]      badva_q;
   logic [NIRQ-1:0]  ip_q;
   logic [31:0]      epc_q;

   logic [NIRQ-1:0]  irq_s;
   logic             irq_pend;
   logic             acc_exc, acc_int, acc_eret;

`ifdef CP0_EXC_IRQ_SYNC_EN
   logic [NIRQ-1:0]  irq_meta_q, irq_sync_q;

   // Two-flop synchronizer for the asynchronous interrupt lines.
   always_ff @(posedge clk) begin
      if (res) begin
         irq_meta_q <= '0;
         irq_sync_q <= '0;
      end else begin
         irq_meta_q <= irq;
         irq_sync_q <= irq_meta_q;
      end
   end

   assign irq_s = irq_sync_q;
`else
   assign irq_s = irq;
`endif

   // Masked interrupt pending: IM-enabled line, IE set, not already at exception level.
   assign irq_pend = (|(irq_s & cp0_status[10 +: NIRQ])) & cp0_status[0] & ~cp0_status[1];

   // Idle-time arbitration: exception > interrupt > ERET.
   always_comb begin
      acc_exc  = 1'b0;
      acc_int  = 1'b0;
      acc_eret = 1'b0;
      if (state_q == StIdle) begin
         if (exc_req)       acc_exc  = 1'b1;
         else if (irq_pend) acc_int  = 1'b1;
         else if (eret_req) acc_eret = 1'b1;
      end
   end

   // Next-state sequencing.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (acc_exc || acc_int) state_d = StSave;
            else if (acc_eret)      state_d = StEret;
         end
         StSave:   state_d = StSetExl;
         StSetExl: state_d = StRedir;
         StEret:   state_d = StRedir;
         StRedir:  state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // State register and request context captured at accept.
   always_ff @(posedge clk) begin
      if (res) begin
         state_q     <= StIdle;
         kind_eret_q <= 1'b0;
         code_q      <= '0;
         pc_q        <= '0;
         bd_q        <= 1'b0;
         bv_q        <= 1'b0;
         badva_q     <= '0;
         ip_q        <= '0;
         epc_q       <= '0;
      end else begin
         state_q <= state_d;
         if (acc_exc) begin
            kind_eret_q <= 1'b0;
            code_q      <= exc_code;
            pc_q        <= exc_pc;
            bd_q        <= exc_bd;
            bv_q        <= exc_badva_valid;
            badva_q     <= exc_badva;
            ip_q        <= irq_s;
         end else if (acc_int) begin
            kind_eret_q <= 1'b0;
            code_q      <= 5'd0;
            pc_q        <= int_pc;
            bd_q        <= int_bd;
            bv_q        <= 1'b0;
            badva_q     <= '0;
            ip_q        <= irq_s;
         end else if (acc_eret) begin
            kind_eret_q <= 1'b1;
         end
         if (state_q == StEret) epc_q <= cp0_epc;
      end
   end

   // Output decode of the registered state; forced quiet while res is asserted so a
   // reset landing mid-sequence issues no further strobe or ack.
   always_comb begin
      in_epc         = '0;
      in_status      = '0;
      in_cause       = '0;
      in_badVAddr    = '0;
      we_epc         = 1'b0;
      we_status      = 1'b0;
      we_cause       = 1'b0;
      we_badVAddr    = 1'b0;
      busy           = 1'b0;
      flush          = 1'b0;
      exc_ack        = 1'b0;
      eret_ack       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      if (!res) begin
         busy  = (state_q != StIdle);
         flush = (state_q != StIdle);
         unique case (state_q)
            StSave: begin
               we_cause                = 1'b1;
               in_cause                = cp0_cause;
               in_cause[31]            = bd_q;
               in_cause[10 +: NIRQ]    = ip_q;
               in_cause[6:2]           = code_q;
               // EPC is preserved on a nested exception (EXL already set).
               we_epc                  = ~cp0_status[1];
               if (we_epc) in_epc      = bd_q ? (pc_q - 32'd4) : pc_q;
               we_badVAddr             = bv_q;
               if (bv_q) in_badVAddr   = badva_q;
            end
            StSetExl: begin
               we_status = 1'b1;
               in_status = cp0_status | 32'h0000_0002;
            end
            StEret: begin
               we_status = 1'b1;
               in_status = cp0_status & ~32'h0000_0002;
            end
            StRedir: begin
               redirect_valid = 1'b1;
               redirect_pc    = kind_eret_q ? epc_q : EXC_VECTOR;
               exc_ack        = ~kind_eret_q;
               eret_ack       = kind_eret_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: drivers push hand-computed per-cycle output records,
// a monitor pops one record for every busy cycle and compares.
module tb_cp0_exc_ctrl;

   logic        clk = 1'b0;
   logic        res;
   logic        exc_req, exc_bd, exc_badva_valid, int_bd, eret_req;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc, exc_badva, int_pc;
   logic [5:0]  irq;
   logic [31:0] cp0_status, cp0_cause, cp0_epc;
   logic [31:0] in_epc, in_status, in_cause, in_badVAddr;
   logic        we_epc, we_status, we_cause, we_badVAddr;
   logic        busy, flush, exc_ack, eret_ack, redirect_valid;
   logic [31:0] redirect_pc;

   always #5 clk = ~clk;

   cp0_exc_ctrl dut (
      .clk(clk), .res(res),
      .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
      .exc_badva_valid(exc_badva_valid), .exc_badva(exc_badva),
      .int_pc(int_pc), .int_bd(int_bd), .eret_req(eret_req), .irq(irq),
      .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
      .in_epc(in_epc), .in_status(in_status), .in_cause(in_cause), .in_badVAddr(in_badVAddr),
      .we_epc(we_epc), .we_status(we_status), .we_cause(we_cause), .we_badVAddr(we_badVAddr),
      .busy(busy), .flush(flush), .exc_ack(exc_ack), .eret_ack(eret_ack),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   typedef struct packed {
      logic        we_epc, we_status, we_cause, we_bad;
      logic [31:0] in_epc, in_status, in_cause, in_bad;
      logic        rv;
      logic [31:0] rpc;
      logic        exc_ack, eret_ack, busy, flush;
   } rec_t;

   rec_t  exp_q[$];
   string name_q[$];
   int    vectors = 0;
   int    miscompares = 0;
   int    busy_cycles = 0;

   function automatic rec_t cur();
      rec_t r;
      r.we_epc = we_epc;   r.we_status = we_status; r.we_cause = we_cause;
      r.we_bad = we_badVAddr;
      r.in_epc = in_epc;   r.in_status = in_status; r.in_cause = in_cause;
      r.in_bad = in_badVAddr;
      r.rv = redirect_valid; r.rpc = redirect_pc;
      r.exc_ack = exc_ack; r.eret_ack = eret_ack; r.busy = busy; r.flush = flush;
      return r;
   endfunction

   function automatic rec_t base();
      rec_t r = '0;
      r.busy  = 1'b1;
      r.flush = 1'b1;
      return r;
   endfunction

   task automatic push(input rec_t r, input string nm);
      exp_q.push_back(r);
      name_q.push_back(nm);
   endtask

   // Exception/interrupt sequence: SAVE, SETEXL, REDIR.
   task automatic push_exc(input string nm, input logic epc_we, input logic [31:0] epc,
                           input logic [31:0] cause, input logic bv, input logic [31:0] bva,
                           input logic [31:0] st);
      rec_t r;
      r = base(); r.we_epc = epc_we; r.in_epc = epc; r.we_cause = 1'b1; r.in_cause = cause;
      r.we_bad = bv; r.in_bad = bva;
      push(r, {nm, "_save"});
      r = base(); r.we_status = 1'b1; r.in_status = st;
      push(r, {nm, "_setexl"});
      r = base(); r.rv = 1'b1; r.rpc = 32'h8000_0180; r.exc_ack = 1'b1;
      push(r, {nm, "_redir"});
   endtask

   task automatic push_eret(input string nm, input logic [31:0] st, input logic [31:0] epc);
      rec_t r;
      r = base(); r.we_status = 1'b1; r.in_status = st;
      push(r, {nm, "_eret"});
      r = base(); r.rv = 1'b1; r.rpc = epc; r.eret_ack = 1'b1;
      push(r, {nm, "_redir"});
   endtask

   // Monitor: every busy cycle consumes one expected record; idle cycles must be quiet.
   initial begin
      rec_t a, e;
      string nm;
      forever begin
         @(negedge clk);
         a = cur();
         if (busy) begin
            busy_cycles++;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_busy: got %h, required no activity", a);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               if (a !== e) begin
                  miscompares++;
                  $display("FAIL %s: got %h required %h", nm, a, e);
               end
            end
         end else if (a !== '0) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_outputs: got %h required all zero", a);
         end
      end
   end

   function automatic logic pick(input int which);
      case (which)
         0:       return busy;
         1:       return exc_ack;
         2:       return eret_ack;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input int which, input string nm);
      int n = 0;
      @(negedge clk);
      while (!pick(which) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!pick(which)) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout_%s: not seen, required within 40 cycles", nm);
      end
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                          input logic bv, input logic [31:0] bva);
      exc_code = code; exc_pc = pc; exc_bd = bd; exc_badva_valid = bv; exc_badva = bva;
      exc_req = 1'b1;
   endtask

   task automatic run_exc(input string nm);
      wait_for(1, nm);
      drive_edge();
      exc_req = 1'b0;
   endtask

   initial begin
      int b0;
      rec_t r;
      res = 1'b1; exc_req = 0; exc_code = 0; exc_pc = 0; exc_bd = 0; exc_badva_valid = 0;
      exc_badva = 0; int_pc = 0; int_bd = 0; eret_req = 0; irq = '0;
      cp0_status = 32'h0000_FF01; cp0_cause = 32'h0000_0783; cp0_epc = 0;
      repeat (3) drive_edge();
      res = 1'b0;
      @(negedge clk);
      vectors++;
      if (cur() !== '0 || busy_cycles != 0) begin
         miscompares++;
         $display("FAIL reset_state: got %h required all zero", cur());
      end

      // Basic exception with valid BadVAddr.
      drive_edge();
      push_exc("exc_basic", 1'b1, 32'h8000_1000, 32'h0000_0393, 1'b1, 32'h0000_1234,
               32'h0000_FF03);
      set_exc(5'd4, 32'h8000_1000, 1'b0, 1'b1, 32'h0000_1234);
      run_exc("exc_basic");

      // Delay-slot exception, BadVAddr not valid.
      push_exc("exc_bd", 1'b1, 32'h8000_2000, 32'h8000_0397, 1'b0, 32'h0, 32'h0000_FF03);
      set_exc(5'd5, 32'h8000_2004, 1'b1, 1'b0, 32'h0000_DEAD);
      run_exc("exc_bd");

      // Nested exception: EXL already set, EPC untouched.
      cp0_status = 32'h0000_FF03;
      push_exc("exc_exl", 1'b0, 32'h0, 32'h0000_038B, 1'b1, 32'h4000_0000, 32'h0000_FF03);
      set_exc(5'd2, 32'h8000_5000, 1'b0, 1'b1, 32'h4000_0000);
      run_exc("exc_exl");

      // ERET.
      cp0_epc = 32'h8000_4000;
      push_eret("eret", 32'h0000_FF01, 32'h8000_4000);
      eret_req = 1'b1;
      wait_for(2, "eret");
      drive_edge();
      eret_req = 1'b0;

      // Simultaneous exception and ERET: exception first.
      cp0_status = 32'h0000_FF01;
      cp0_epc    = 32'h8000_7000;
      push_exc("sim_exc", 1'b1, 32'h8000_6000, 32'h0000_03B3, 1'b0, 32'h0, 32'h0000_FF03);
      push_eret("sim_eret", 32'h0000_FF01, 32'h8000_7000);
      set_exc(5'd12, 32'h8000_6000, 1'b0, 1'b0, 32'h0);
      eret_req = 1'b1;
      run_exc("sim_exc");
      wait_for(2, "sim_eret");
      drive_edge();
      eret_req = 1'b0;

      // Interrupt on IP2.
      cp0_status = 32'h0000_0401;
      int_pc = 32'h8000_3000; int_bd = 1'b0;
      push_exc("irq", 1'b1, 32'h8000_3000, 32'h0000_0783, 1'b0, 32'h0, 32'h0000_0403);
      irq = 6'b000001;
      wait_for(0, "irq_busy");
      drive_edge();
      irq = '0;
      wait_for(1, "irq_ack");
      repeat (4) drive_edge();

      // Interrupt masked by IE=0, then by EXL=1.
      cp0_status = 32'h0000_0400;
      irq = 6'b000001;
      b0 = busy_cycles;
      repeat (8) drive_edge();
      vectors++;
      if (busy_cycles != b0) begin
         miscompares++;
         $display("FAIL irq_ie0: got %0d busy cycles required 0", busy_cycles - b0);
      end
      cp0_status = 32'h0000_0403;
      b0 = busy_cycles;
      repeat (8) drive_edge();
      vectors++;
      if (busy_cycles != b0) begin
         miscompares++;
         $display("FAIL irq_exl1: got %0d busy cycles required 0", busy_cycles - b0);
      end
      irq = '0;
      repeat (4) drive_edge();

      // Reset landing on SETEXL.
      cp0_status = 32'h0000_FF01;
      r = base(); r.we_epc = 1'b1; r.in_epc = 32'h8000_8000; r.we_cause = 1'b1;
      r.in_cause = 32'h0000_0393;
      push(r, "res_save");
      set_exc(5'd4, 32'h8000_8000, 1'b0, 1'b0, 32'h0);
      wait_for(0, "res_busy");
      drive_edge();
      res = 1'b1;
      exc_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (cur() !== '0) begin
         miscompares++;
         $display("FAIL res_during_setexl: got %h required all zero", cur());
      end
      drive_edge();
      res = 1'b0;
      b0 = busy_cycles;
      repeat (4) @(negedge clk);
      vectors++;
      if (busy || busy_cycles != b0 || cur() !== '0) begin
         miscompares++;
         $display("FAIL res_after: got busy_cycles %0d outputs %h required 0 and zero",
                  busy_cycles - b0, cur());
      end

      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d records left required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
